// File: rtl/alu_operand_b_stage_if.sv
// Decode-to-ALU operand B bundle: decode-side controls and data in, registered ID/EX slot out.
// The master modport drives the decode side; the slave modport is the stage itself.
interface alu_operand_b_stage_if #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned IMM_WIDTH = 16
);
  logic                 in_valid;
  logic                 stall;
  logic                 flush;
  logic                 alu_src;
  logic [1:0]           imm_mode;
  logic [IMM_WIDTH-1:0] imm;
  logic [WIDTH-1:0]     read_data2;
  logic [1:0]           fwd_sel;
  logic [WIDTH-1:0]     fwd_exmem;
  logic [WIDTH-1:0]     fwd_memwb;
  logic                 out_valid;
  logic [WIDTH-1:0]     operand_b;
  logic [WIDTH-1:0]     store_data;

  modport master (
    output in_valid, stall, flush, alu_src, imm_mode, imm,
           read_data2, fwd_sel, fwd_exmem, fwd_memwb,
    input  out_valid, operand_b, store_data
  );

  modport slave (
    input  in_valid, stall, flush, alu_src, imm_mode, imm,
           read_data2, fwd_sel, fwd_exmem, fwd_memwb,
    output out_valid, operand_b, store_data
  );
endinterface

// File: rtl/alu_operand_b_stage.sv
// ALU operand B select (regfile / forwarded / extended immediate) registered into the ID/EX slot,
// with store data, stall, flush and valid. Define OPB_FWD_EN to enable the EX/MEM and MEM/WB forwarding paths.
module alu_operand_b_stage #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned IMM_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  alu_operand_b_stage_if.slave bus
);
  localparam int unsigned PAD = (WIDTH > IMM_WIDTH) ? (WIDTH - IMM_WIDTH) : 1;

  logic [WIDTH-1:0] rs2_val;
  logic [WIDTH-1:0] imm_ext;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] operand_b_q, operand_b_d;
  logic [WIDTH-1:0] store_data_q, store_data_d;

`ifdef OPB_FWD_EN
  always_comb begin
    rs2_val = bus.read_data2;
    case (bus.fwd_sel)
      2'b01:   rs2_val = bus.fwd_exmem;
      2'b10:   rs2_val = bus.fwd_memwb;
      default: rs2_val = bus.read_data2;
    endcase
  end
`else
  logic unused_fwd;
  assign unused_fwd = ^{bus.fwd_sel, bus.fwd_exmem, bus.fwd_memwb};

  always_comb begin
    rs2_val = bus.read_data2;
  end
`endif

  // Full-width immediates have no padding to fill, so every mode is a pass-through.
  generate
    if (IMM_WIDTH >= WIDTH) begin : g_imm_full
      logic unused_mode;
      assign unused_mode = ^bus.imm_mode;

      always_comb begin
        imm_ext = bus.imm[WIDTH-1:0];
      end
    end else begin : g_imm_ext
      always_comb begin
        imm_ext = {{PAD{bus.imm[IMM_WIDTH-1]}}, bus.imm};
        case (bus.imm_mode)
          2'b01:   imm_ext = {{PAD{1'b0}}, bus.imm};
          2'b10:   imm_ext = {bus.imm, {PAD{1'b0}}};
          default: imm_ext = {{PAD{bus.imm[IMM_WIDTH-1]}}, bus.imm};
        endcase
      end
    end
  endgenerate

  // Flush takes priority over stall: a killed slot must not survive a hold.
  always_comb begin
    out_valid_d  = out_valid_q;
    operand_b_d  = operand_b_q;
    store_data_d = store_data_q;
    if (bus.flush) begin
      out_valid_d  = 1'b0;
      operand_b_d  = '0;
      store_data_d = '0;
    end else if (!bus.stall) begin
      out_valid_d  = bus.in_valid;
      operand_b_d  = bus.alu_src ? imm_ext : rs2_val;
      store_data_d = rs2_val;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q  <= 1'b0;
      operand_b_q  <= '0;
      store_data_q <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      operand_b_q  <= operand_b_d;
      store_data_q <= store_data_d;
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.operand_b  = operand_b_q;
  assign bus.store_data = store_data_q;
endmodule

// File: tb/tb_alu_operand_b_stage.sv
// Scoreboard bench for alu_operand_b_stage: directed scenarios plus random traffic against a
// reference model; a second full-width instance covers the WIDTH = IMM_WIDTH case.
module tb_alu_operand_b_stage;
  localparam int unsigned W  = 32;
  localparam int unsigned IW = 16;

  logic clk = 1'b0;
  logic reset;
  logic reset16;
  always #5 clk = ~clk;

  alu_operand_b_stage_if #(.WIDTH(W), .IMM_WIDTH(IW)) bus ();
  alu_operand_b_stage #(.WIDTH(W), .IMM_WIDTH(IW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  alu_operand_b_stage_if #(.WIDTH(16), .IMM_WIDTH(16)) bus16 ();
  alu_operand_b_stage #(.WIDTH(16), .IMM_WIDTH(16)) dut16 (
    .clk   (clk),
    .reset (reset16),
    .bus   (bus16)
  );

  typedef struct {
    logic        v;
    logic [31:0] b;
    logic [31:0] sd;
  } exp_t;

  exp_t sbq[$];
  exp_t model;
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_ext(input logic [15:0] imm, input logic [1:0] mode);
    logic [31:0] v;
    v = 32'(imm);
    case (mode)
      2'd1:    return v;
      2'd2:    return v * 32'd65536;
      default: return (v >= 32'h8000) ? (v + 32'hFFFF_0000) : v;
    endcase
  endfunction

  function automatic logic [31:0] ref_rs2(input logic [31:0] rd2, input logic [1:0] fs,
                                          input logic [31:0] ex, input logic [31:0] mw);
`ifdef OPB_FWD_EN
    if (fs == 2'd1) return ex;
    if (fs == 2'd2) return mw;
`endif
    return rd2;
  endfunction

  task automatic step(input logic rst, input logic iv, input logic st, input logic fl,
                      input logic src, input logic [1:0] mode, input logic [15:0] imm,
                      input logic [31:0] rd2, input logic [1:0] fs,
                      input logic [31:0] ex, input logic [31:0] mw);
    reset          = rst;
    bus.in_valid   = iv;
    bus.stall      = st;
    bus.flush      = fl;
    bus.alu_src    = src;
    bus.imm_mode   = mode;
    bus.imm        = imm;
    bus.read_data2 = rd2;
    bus.fwd_sel    = fs;
    bus.fwd_exmem  = ex;
    bus.fwd_memwb  = mw;
    if (rst || fl) begin
      model.v = 1'b0; model.b = '0; model.sd = '0;
    end else if (!st) begin
      model.v  = iv;
      model.sd = ref_rs2(rd2, fs, ex, mw);
      model.b  = src ? ref_ext(imm, mode) : model.sd;
    end
    sbq.push_back(model);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      exp_t e;
      e = sbq.pop_front();
      check("out_valid", 32'(bus.out_valid), 32'(e.v));
      check("operand_b", bus.operand_b, e.b);
      check("store_data", bus.store_data, e.sd);
    end
  end

  initial begin
    model = '{v: 1'b0, b: '0, sd: '0};
    reset16 = 1'b1;
    bus16.in_valid = 1'b0; bus16.stall = 1'b0; bus16.flush = 1'b0; bus16.alu_src = 1'b0;
    bus16.imm_mode = 2'd0; bus16.imm = '0; bus16.read_data2 = '0; bus16.fwd_sel = 2'd0;
    bus16.fwd_exmem = '0; bus16.fwd_memwb = '0;

    // Reset with every input nonzero, then first load
    repeat (2) step(1, 1, 1, 1, 1, 2'd3, 16'hFFFF, 32'hDEAD_BEEF, 2'd1, 32'h1111_1111, 32'h2222_2222);
    step(0, 1, 0, 0, 0, 2'd0, 16'h0000, 32'h5, 2'd0, 32'h0, 32'h0);

    // Immediate modes
    for (int m = 0; m < 4; m++)
      step(0, 1, 0, 0, 1, 2'(m), 16'h8001, 32'h5, 2'd0, 32'h0, 32'h0);

    // Forwarding selects, then immediate with forwarded store data
    for (int f = 0; f < 4; f++)
      step(0, 1, 0, 0, 0, 2'd0, 16'h0, 32'd1, 2'(f), 32'd2, 32'd3);
    step(0, 1, 0, 0, 1, 2'd0, 16'd7, 32'd1, 2'd1, 32'd2, 32'd3);

    // Stall holds for three cycles while inputs move
    step(0, 1, 0, 0, 0, 2'd0, 16'h0, 32'd9, 2'd0, 32'd0, 32'd0);
    for (int k = 0; k < 3; k++)
      step(0, 0, 1, 0, 0, 2'd0, 16'h0, 32'(10 + k), 2'd0, 32'd0, 32'd0);
    step(0, 1, 0, 0, 0, 2'd0, 16'h0, 32'd12, 2'd0, 32'd0, 32'd0);

    // Flush beats stall, then an invalid load stays a bubble
    step(0, 1, 0, 0, 0, 2'd0, 16'h0, 32'd9, 2'd0, 32'd0, 32'd0);
    step(0, 1, 1, 1, 0, 2'd0, 16'h0, 32'd7, 2'd0, 32'd0, 32'd0);
    step(0, 0, 0, 0, 0, 2'd0, 16'h0, 32'd4, 2'd0, 32'd0, 32'd0);

    // Reset during a stall clears the slot
    step(0, 1, 0, 0, 0, 2'd0, 16'h0, 32'd6, 2'd0, 32'd0, 32'd0);
    step(1, 1, 1, 0, 0, 2'd0, 16'h0, 32'd6, 2'd0, 32'd0, 32'd0);
    step(0, 1, 1, 0, 0, 2'd0, 16'h0, 32'd8, 2'd0, 32'd0, 32'd0);
    step(0, 1, 0, 0, 0, 2'd0, 16'h0, 32'd8, 2'd0, 32'd0, 32'd0);

    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 99) < 3, 1'($urandom), $urandom_range(0, 99) < 25,
           $urandom_range(0, 99) < 10, 1'($urandom), 2'($urandom), 16'($urandom),
           $urandom, 2'($urandom), $urandom, $urandom);

    for (int k = 0; k < 5 && sbq.size() > 0; k++) @(negedge clk);
    n_checks++;
    if (sbq.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", sbq.size());
    end

    // Full-width immediate: all modes pass through
    @(posedge clk); #2;
    reset16 = 1'b0;
    bus16.in_valid = 1'b1;
    bus16.alu_src  = 1'b1;
    bus16.imm      = 16'hABCD;
    bus16.read_data2 = 16'h1234;
    for (int m = 0; m < 4; m++) begin
      bus16.imm_mode = 2'(m);
      @(posedge clk); #2;
      check("w16_operand_b", 32'(bus16.operand_b), 32'h0000_ABCD);
      check("w16_store_data", 32'(bus16.store_data), 32'h0000_1234);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_operand_b_stage.md
# alu_operand_b_stage

Parametrised successor to the ALU second-operand select. Picks operand B for the ALU from the register file, an extended immediate, or one of two forwarded results, and registers the result into the ID/EX boundary. It also registers the forwarded rs2 value as store data, so both sit in the same pipeline slot. Handles stall (hold), flush (bubble) and a valid bit, between the decode stage and the ALU.

## Interface
Parameters:
- WIDTH, 32, datapath width in bits
- IMM_WIDTH, 16, raw immediate width; must satisfy 1 <= IMM_WIDTH <= WIDTH

Ports:
- clk  input  1  rising-edge clock, the only clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  decode slot holds a real instruction
- stall  input  1  hold the stage register (hazard unit)
- flush  input  1  replace the next register contents with a bubble
- alu_src  input  1  0 = operand B is the rs2 path, 1 = operand B is the immediate
- imm_mode  input  2  00 sign-extend, 01 zero-extend, 10 upper, 11 treated as 00
- imm  input  IMM_WIDTH  raw immediate
- read_data2  input  WIDTH  register-file rs2 value
- fwd_sel  input  2  00 regfile, 01 EX/MEM, 10 MEM/WB, 11 treated as 00
- fwd_exmem  input  WIDTH  EX/MEM forwarded result
- fwd_memwb  input  WIDTH  MEM/WB forwarded result
- out_valid  output  1  registered valid bit
- operand_b  output  WIDTH  registered ALU operand B
- store_data  output  WIDTH  registered forwarded rs2 value, independent of alu_src

## Operation
- rs2 path: rs2_val = fwd_exmem if fwd_sel=01; fwd_memwb if fwd_sel=10; otherwise read_data2.
- Immediate extension, imm_ext (WIDTH bits):
  - Sign-extend: bit IMM_WIDTH-1 is replicated into the upper bits.
  - Zero-extend: the upper bits are 0.
  - Upper: imm occupies [WIDTH-1:WIDTH-IMM_WIDTH] and the lower bits are 0.
  - If IMM_WIDTH = WIDTH, all modes pass imm unchanged.
- Next operand: next_b = alu_src ? imm_ext : rs2_val.
- Next store data: next_sd = rs2_val, whatever alu_src is.
- Register update on each rising clk, in priority order:
  1. reset: out_valid=0, operand_b=0, store_data=0.
  2. flush: out_valid=0, operand_b=0, store_data=0. Flush beats stall.
  3. stall: all three outputs hold their values.
  4. Otherwise load: out_valid=in_valid, operand_b=next_b, store_data=next_sd.
- Data is loaded even when in_valid=0. Consumers must qualify with out_valid.
- No internal state other than the three registers. The block has no FSM. Its only states are the bubble (out_valid=0) and the occupied slot (out_valid=1).

## Timing
- Latency from inputs to outputs is 1 cycle. Outputs are registered only and have no combinational path from the inputs.
- All outputs reset to 0 on the first rising edge with reset=1. They stay 0 while reset is held.
- Reset asserted mid-stall clears the slot. After reset deasserts, the first load occurs on the next edge with stall=0.
- Stall held for N cycles keeps the outputs constant for N edges. Input changes during the stall are lost. The hazard unit must hold the decode slot.
- stall and flush in the same cycle: the result is a bubble.
- When fwd_sel changes, the new forwarded value is captured at the next load edge. No forwarded value is stored across a stall.

## Configuration
- Macro OPB_FWD_EN.
- Defined: forwarding paths are active as described in Operation.
- Undefined: rs2_val = read_data2 always. fwd_sel, fwd_exmem and fwd_memwb stay as ports but are ignored. Immediate, stall, flush and reset behaviour are unchanged.

## Test plan
- Reset: hold reset=1 for 2 cycles with all inputs at nonzero values -> out_valid=0, operand_b=0, store_data=0. After release with in_valid=1, alu_src=0, read_data2=32'h0000_0005, fwd_sel=00 -> one cycle later out_valid=1, operand_b=5, store_data=5.
- Immediate modes, WIDTH=32, IMM_WIDTH=16, imm=16'h8001, alu_src=1 -> operand_b is:
  - 32'hFFFF_8001 for imm_mode=00
  - 32'h0000_8001 for imm_mode=01
  - 32'h8001_0000 for imm_mode=10
  - 32'hFFFF_8001 for imm_mode=11
- Forwarding with OPB_FWD_EN defined: read_data2=1, fwd_exmem=2, fwd_memwb=3, alu_src=0 -> operand_b is 1, 2, 3, 1 for fwd_sel = 00, 01, 10, 11.
  - With alu_src=1, imm=7, fwd_sel=01 -> operand_b=7, store_data=2.
  - Without the macro, fwd_sel=01 -> operand_b=1.
- Stall: load operand_b=9, then assert stall for 3 cycles while read_data2 cycles through 10, 11, 12 -> operand_b stays 9 and out_valid stays 1. On release with read_data2=12 -> operand_b=12.
- Flush vs stall: with a valid slot holding 9, assert stall=1 and flush=1 together -> next edge gives out_valid=0, operand_b=0, store_data=0. A following in_valid=0 load keeps out_valid=0.
- Width parameter: WIDTH=16, IMM_WIDTH=16, imm=16'hABCD, alu_src=1 -> operand_b=16'hABCD for every imm_mode.
